alu_seq_nbit: RTL and testbench
===============================

// Module: alu_seq_nbit
// PURPOSE
//  Parametrised multi-cycle successor to the combinational datapath ALU for the
//  RV32I core. Adds barrel-free iterative shifts by a full shift amount, an
//  iterative MUL (low n bits) and a start/ready/valid handshake.
//  ALUout and the Z/V/C/S flags are registered and held until the next result.
//  Sits in EX; the control unit stalls the pipeline while ready=0.
// PARAMETERS
//  n    32  datapath width; power of 2, >= 8
//  SHW  $clog2(n)  localparam; shift-amount width, taken from B[SHW-1:0]
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    reset, asynchronous, active-high
//  start        in   1    request; accepted only on a clk edge where ready=1
//  A            in   n    operand A; captured on accept
//  B            in   n    operand B; shift amount is B[SHW-1:0]; captured on accept
//  alu_control  in   4    operation; captured on accept
//  ready        out  1    1 = idle, can accept start
//  valid        out  1    1-cycle pulse: ALUout/flags updated this cycle
//  ALUout       out  n    registered result
//  Z            out  1    ALUout == 0
//  V            out  1    signed overflow (ADD/SUB only, else 0)
//  C            out  1    carry out (ADD/SUB only, else 0)
//  S            out  1    ALUout[n-1]
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ready=1, valid=0, ALUout=0, Z=1, V=C=S=0.
//   Reset mid-operation aborts the operation; no valid is produced for it.
//  Encoding (alu_control):
//   0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SRL, 0110 SRA, 0111 SLL,
//   1000 SLT, 1001 SLTU, 1010 PASS(A), 1011 MUL. Codes 11xx give ALUout=0, flags Z=1.
//  FSM: IDLE -> (start, single-cycle op) DONE; -> (start, shift, shamt>0) SHIFT;
//   -> (start, MUL) MUL. SHIFT: one bit per cycle, counter=shamt, -> DONE at 0.
//   MUL: shift-add over n cycles -> DONE. DONE: valid=1, ready=1 -> IDLE,
//   or straight back into a new op if start is asserted that cycle.
//  Latency (accept at edge k; valid high in the cycle after edge):
//   single-cycle ops and shifts with shamt=0: k+1; shift: k+1+shamt; MUL: k+1+n.
//  ready=0 from the edge after accept until valid. start while ready=0 is ignored,
//   with no effect on the operation in flight.
//  Back-to-back: start in the valid cycle is accepted (ready=1 there).
//  ADD: {C,ALUout} = A+B. SUB: {C,ALUout} = A+~B+1 (C=1 means no borrow, A>=B unsigned).
//  V(ADD) = A[n-1]==B[n-1] && ALUout[n-1]!=A[n-1].
//  V(SUB) = A[n-1]!=B[n-1] && ALUout[n-1]!=A[n-1].
//  SLT: signed compare A<B -> 1 else 0; SLTU: unsigned. Result is zero-extended.
//  SRL fills with 0, SRA with A[n-1], SLL with 0 at the LSB; shamt range 0..n-1.
//  MUL: low n bits of A*B (sign-agnostic). C=V=0 for all non-ADD/SUB ops.
//  Z and S are always computed from the final ALUout.
//  Outputs change only with valid; they hold between results.
// TESTING (n=32)
//  1. ADD A=0x7FFFFFFF B=1 -> ALUout=0x80000000, V=1 C=0 S=1 Z=0; valid at k+1.
//  2. SUB 5-5 -> 0, Z=1 C=1 V=0; SUB 3-5 -> 0xFFFFFFFE, C=0 S=1 V=0.
//  3. SRA A=0x80000000 B=4 -> 0xF8000000, ready=0 k+1..k+4, valid k+5;
//     SRL same -> 0x08000000; SLL B=0 -> A, valid k+1.
//  4. SLT A=0xFFFFFFFF B=1 -> 1; SLTU same operands -> 0; PASS A=0x1234 -> 0x1234.
//  5. MUL A=0x00010003 B=0x00020005 -> 0x000B000F, valid k+33.
//     A start pulse at k+10 is ignored, and the result is unchanged.
//  6. rst high at k+5 of MUL -> ready=1 valid=0 ALUout=0 Z=1 at once, with no valid later.
//     An ADD started in a valid cycle is accepted, and its valid follows one cycle later.

Source files
------------

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: multi-cycle n-bit ALU with start/ready/valid handshake.
// Shifts run one bit per cycle, MUL is an n-cycle shift-add; results and flags held until the next valid.
`default_nettype none

module alu_seq_nbit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [3:0]   alu_control,
  output logic         ready,
  output logic         valid,
  output logic [n-1:0] ALUout,
  output logic         Z,
  output logic         V,
  output logic         C,
  output logic         S
);

  localparam int SHW = $clog2(n);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_N   = (SHW+1)'(n);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     op_r;
  logic [n-1:0]   acc, mcand, mplier;
  logic [SHW:0]   cnt;

  logic           accept, is_sub, is_shift;
  logic [SHW-1:0] shamt;
  logic [n-1:0]   b_opnd, shift_step, mul_step;
  logic [n:0]     sum;
  logic [n-1:0]   one_res, res_nxt;
  logic           one_c, one_v, c_nxt, v_nxt;

  assign ready    = (state == IDLE) || (state == DONE);
  assign valid    = (state == DONE);
  assign accept   = start && ready;
  assign shamt    = B[SHW-1:0];
  assign is_shift = (alu_control == OP_SRL) || (alu_control == OP_SRA) || (alu_control == OP_SLL);

  // SUB is A + ~B + 1 so that C reads as "no borrow"
  assign is_sub = (alu_control == OP_SUB);
  assign b_opnd = is_sub ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_opnd} + {{n{1'b0}}, is_sub};

  always_comb begin
    unique case (op_r)
      OP_SRA:  shift_step = {acc[n-1], acc[n-1:1]};
      OP_SLL:  shift_step = {acc[n-2:0], 1'b0};
      default: shift_step = {1'b0, acc[n-1:1]};
    endcase
  end

  assign mul_step = acc + (mplier[0] ? mcand : '0);

  // Result of ops completing in the accept cycle; shifts land here only with shamt=0
  always_comb begin
    one_res = '0;
    one_c   = 1'b0;
    one_v   = 1'b0;
    case (alu_control)
      OP_ADD: begin
        one_res = sum[n-1:0];
        one_c   = sum[n];
        one_v   = (A[n-1] == B[n-1]) && (sum[n-1] != A[n-1]);
      end
      OP_SUB: begin
        one_res = sum[n-1:0];
        one_c   = sum[n];
        one_v   = (A[n-1] != B[n-1]) && (sum[n-1] != A[n-1]);
      end
      OP_AND:  one_res = A & B;
      OP_OR:   one_res = A | B;
      OP_XOR:  one_res = A ^ B;
      OP_SRL, OP_SRA, OP_SLL, OP_PASS: one_res = A;
      OP_SLT:  one_res = {{(n-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: one_res = {{(n-1){1'b0}}, (A < B)};
      default: one_res = '0;
    endcase
  end

  always_comb begin
    res_nxt = one_res;
    c_nxt   = one_c;
    v_nxt   = one_v;
    if (state == SHIFT) begin
      res_nxt = shift_step;
      c_nxt   = 1'b0;
      v_nxt   = 1'b0;
    end else if (state == MUL) begin
      res_nxt = mul_step;
      c_nxt   = 1'b0;
      v_nxt   = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (alu_control == OP_MUL)           state_nxt = MUL;
          else if (is_shift && shamt != '0)    state_nxt = SHIFT;
          else                                 state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT, MUL: if (cnt == CNT_ONE) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ALUout <= '0;
      Z      <= 1'b1;
      V      <= 1'b0;
      C      <= 1'b0;
      S      <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= alu_control;
        acc    <= (alu_control == OP_MUL) ? '0 : A;
        mcand  <= A;
        mplier <= B;
        cnt    <= (alu_control == OP_MUL) ? CNT_N : {1'b0, shamt};
      end else if (state == SHIFT) begin
        acc <= shift_step;
        cnt <= cnt - CNT_ONE;
      end else if (state == MUL) begin
        acc    <= mul_step;
        mcand  <= {mcand[n-2:0], 1'b0};
        mplier <= {1'b0, mplier[n-1:1]};
        cnt    <= cnt - CNT_ONE;
      end
      // Visible outputs move only on the edge that enters DONE
      if (state_nxt == DONE) begin
        ALUout <= res_nxt;
        Z      <= (res_nxt == '0);
        S      <= res_nxt[n-1];
        C      <= c_nxt;
        V      <= v_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_nbit.sv
// tb_alu_seq_nbit: table-driven checks of alu_seq_nbit (n=32) plus handshake/reset corner sequences.
`default_nettype none

module tb_alu_seq_nbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  alu_control = '0;
  logic        ready, valid, Z, V, C, S;
  logic [31:0] ALUout;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq_nbit #(.n(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .alu_control(alu_control),
    .ready(ready), .valid(valid), .ALUout(ALUout), .Z(Z), .V(V), .C(C), .S(S)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;   // {Z,V,C,S}
    int          lat;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op and returns at the negedge of its valid cycle (or at the bound).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output int ready_hi);
    @(negedge clk);
    start = 1'b1; alu_control = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    ready_hi = 0;
    while (!valid && cyc < 40) begin
      if (ready) ready_hi++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, rdy, seen;

    tv[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1};
    tv[1]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010, 1};
    tv[2]  = '{4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0001, 1};
    tv[3]  = '{4'b0110, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0001, 5};
    tv[4]  = '{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 5};
    tv[5]  = '{4'b0111, 32'h00001234, 32'h00000000, 32'h00001234, 4'b0000, 1};
    tv[6]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1};
    tv[7]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 1};
    tv[8]  = '{4'b1010, 32'h00001234, 32'hDEADBEEF, 32'h00001234, 4'b0000, 1};
    tv[9]  = '{4'b1011, 32'h00010003, 32'h00020005, 32'h000B000F, 4'b0000, 33};
    tv[10] = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001, 1};
    tv[11] = '{4'b0011, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 4'b0000, 1};
    tv[12] = '{4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1};
    tv[13] = '{4'b1100, 32'h00000005, 32'h00000007, 32'h00000000, 4'b1000, 1};
    tv[14] = '{4'b0111, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b0001, 32};
    tv[15] = '{4'b0101, 32'h80000000, 32'h00000021, 32'h40000000, 4'b0000, 2};
    tv[16] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
    tv[17] = '{4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110, 1};
    tv[18] = '{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};

    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_out", ALUout, 32'd0);
    chk("reset_flags", {28'd0, Z, V, C, S}, 32'b1000);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, cyc, rdy);
      chk($sformatf("v%0d_latency", i), cyc, tv[i].lat);
      chk($sformatf("v%0d_ready_busy", i), rdy, 0);
      chk($sformatf("v%0d_out", i), ALUout, tv[i].res);
      chk($sformatf("v%0d_flags", i), {28'd0, Z, V, C, S}, {28'd0, tv[i].flg});
    end

    // MUL with a stray start while busy
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1011; A = 32'h00010003; B = 32'h00020005;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!valid && cyc < 40) begin
      if (cyc == 10) begin
        chk("mul_busy_ready", {31'd0, ready}, 32'd0);
        start = 1'b1; alu_control = 4'b0000; A = 32'h1; B = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("mul_ignore_latency", cyc, 33);
    chk("mul_ignore_out", ALUout, 32'h000B000F);

    // Back-to-back: new ADD issued in the valid cycle of a PASS
    do_op(4'b1010, 32'h000000AA, 32'h0, cyc, rdy);
    chk("b2b_pass_out", ALUout, 32'h000000AA);
    chk("b2b_ready_in_valid", {31'd0, ready}, 32'd1);
    start = 1'b1; alu_control = 4'b0000; A = 32'd2; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_add_valid", {31'd0, valid}, 32'd1);
    chk("b2b_add_out", ALUout, 32'd5);

    // Reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1011; A = 32'h3; B = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    chk("rst_mid_out", ALUout, 32'd0);
    chk("rst_mid_flags", {28'd0, Z, V, C, S}, 32'b1000);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("rst_no_late_valid", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
